// File: rtl/md5_pkg.sv
// Shared types and constants for the md5 front-end: FSM state encoding and
// MD5 padding geometry.
package md5_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StNewtext,
        StFill,
        StPad,
        StLoad,
        StWait
    } md5_state_e;

    localparam logic [7:0]  MD5_PAD_BYTE = 8'h80;
    localparam int unsigned MD5_LEN_POS  = 56;
    localparam int unsigned MD5_BEATS    = 4;

endpackage

// File: rtl/md5_feeder_if.sv
// Byte-stream input and md5 core-facing signals of md5_feeder.
// master = the feeder itself, slave = the surrounding producer/core side.
interface md5_feeder_if;

    logic         din_valid_i;
    logic [7:0]   din_i;
    logic         din_last_i;
    logic         din_ready_o;
    logic         newtext_o;
    logic         load_o;
    logic [127:0] data_o;
    logic         core_ready_i;
    logic         busy_o;
    logic         done_o;

    modport master (
        input  din_valid_i,
        input  din_i,
        input  din_last_i,
        input  core_ready_i,
        output din_ready_o,
        output newtext_o,
        output load_o,
        output data_o,
        output busy_o,
        output done_o
    );

    modport slave (
        output din_valid_i,
        output din_i,
        output din_last_i,
        output core_ready_i,
        input  din_ready_o,
        input  newtext_o,
        input  load_o,
        input  data_o,
        input  busy_o,
        input  done_o
    );

endinterface

// File: rtl/md5_pad_byte_gen.sv
// Selects the MD5 padding byte for a block position: 0x80 marker first, then
// zeros, then the little-endian 64-bit message bit length in positions 56..63.
module md5_pad_byte_gen
    import md5_pkg::*;
(
    input  logic [5:0]  pos,
    input  logic        sent80,
    input  logic        len_ok,
    input  logic [63:0] bit_len,
    output logic [7:0]  pad_byte
);

    always_comb begin
        pad_byte = 8'h00;
        if (!sent80) begin
            pad_byte = MD5_PAD_BYTE;
        end else if (len_ok && (pos >= 6'(MD5_LEN_POS))) begin
            pad_byte = bit_len[{pos[2:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/md5_feeder.sv
// Packs a byte stream into padded 512-bit MD5 blocks, delivered as four 128-bit
// load beats per block. Optional macro MD5_FEEDER_EMPTY_EN adds msg_empty_i.
module md5_feeder
    import md5_pkg::*;
#(
    parameter int unsigned LEN_W = 32
) (
    input logic          clk,
    input logic          reset,
`ifdef MD5_FEEDER_EMPTY_EN
    input logic          msg_empty_i,
`endif
    md5_feeder_if.master bus
);

    md5_state_e   state_q, state_d;
    logic [127:0] beat_q, beat_d;
    logic [3:0]   byte_idx_q, byte_idx_d;
    logic [1:0]   beat_idx_q, beat_idx_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic         pad_mode_q, pad_mode_d;
    logic         sent80_q, sent80_d;
    logic         len_ok_q, len_ok_d;
    logic         empty_q, empty_d;

    logic         newtext_q, load_q, din_ready_q, busy_q, done_q, done_d;
    logic [127:0] data_q;

    logic         start_empty;
    logic [5:0]   pos;
    logic [63:0]  bit_len;
    logic         len_now;
    logic [7:0]   pad_byte;
    logic         wr_en;
    logic [7:0]   wr_byte;
    logic [6:0]   wr_off;

`ifdef MD5_FEEDER_EMPTY_EN
    assign start_empty = msg_empty_i;
`else
    assign start_empty = 1'b0;
`endif

    assign pos     = {beat_idx_q, byte_idx_q};
    assign bit_len = 64'(byte_cnt_q) << 3;
    // Length field starts at 56 only if the 0x80 marker already went out earlier.
    assign len_now = len_ok_q | (sent80_q && (pos == 6'(MD5_LEN_POS)));
    // Word 0 sits in the top 32 bits; bytes are little-endian within a word.
    assign wr_off  = {~byte_idx_q[3:2], byte_idx_q[1:0], 3'b000};

    md5_pad_byte_gen u_pad_byte_gen (
        .pos      (pos),
        .sent80   (sent80_q),
        .len_ok   (len_now),
        .bit_len  (bit_len),
        .pad_byte (pad_byte)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        byte_idx_d = byte_idx_q;
        beat_idx_d = beat_idx_q;
        byte_cnt_d = byte_cnt_q;
        pad_mode_d = pad_mode_q;
        sent80_d   = sent80_q;
        len_ok_d   = len_ok_q;
        empty_d    = empty_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_byte    = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (start_empty) begin
                    empty_d = 1'b1;
                    state_d = StNewtext;
                end else if (bus.din_valid_i) begin
                    empty_d = 1'b0;
                    state_d = StNewtext;
                end
            end
            StNewtext: begin
                byte_cnt_d = '0;
                byte_idx_d = '0;
                beat_idx_d = '0;
                pad_mode_d = empty_q;
                sent80_d   = 1'b0;
                len_ok_d   = 1'b0;
                empty_d    = 1'b0;
                state_d    = empty_q ? StPad : StFill;
            end
            StFill: begin
                if (bus.din_valid_i) begin
                    wr_en      = 1'b1;
                    wr_byte    = bus.din_i;
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    if (bus.din_last_i) begin
                        pad_mode_d = 1'b1;
                    end
                    if (byte_idx_q == 4'd15) begin
                        state_d = StLoad;
                    end else if (bus.din_last_i) begin
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                wr_en    = 1'b1;
                wr_byte  = pad_byte;
                sent80_d = 1'b1;
                len_ok_d = len_now;
                if (byte_idx_q == 4'd15) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                beat_idx_d = beat_idx_q + 2'd1;
                if (beat_idx_q == 2'(MD5_BEATS - 1)) begin
                    state_d = StWait;
                end else begin
                    state_d = pad_mode_q ? StPad : StFill;
                end
            end
            StWait: begin
                if (bus.core_ready_i) begin
                    if (len_ok_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (pad_mode_q) begin
                        state_d = StPad;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            beat_d[wr_off +: 8] = wr_byte;
            byte_idx_d          = byte_idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            byte_idx_q  <= '0;
            beat_idx_q  <= '0;
            byte_cnt_q  <= '0;
            pad_mode_q  <= 1'b0;
            sent80_q    <= 1'b0;
            len_ok_q    <= 1'b0;
            empty_q     <= 1'b0;
            newtext_q   <= 1'b0;
            load_q      <= 1'b0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            byte_idx_q  <= byte_idx_d;
            beat_idx_q  <= beat_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            pad_mode_q  <= pad_mode_d;
            sent80_q    <= sent80_d;
            len_ok_q    <= len_ok_d;
            empty_q     <= empty_d;
            // Outputs are registered from the next state so they track state_q exactly.
            newtext_q   <= (state_d == StNewtext);
            load_q      <= (state_d == StLoad);
            din_ready_q <= (state_d == StFill);
            busy_q      <= (state_d != StIdle);
            done_q      <= done_d;
            data_q      <= (state_d == StLoad) ? beat_d : '0;
        end
    end

    assign bus.din_ready_o = din_ready_q;
    assign bus.newtext_o   = newtext_q;
    assign bus.load_o      = load_q;
    assign bus.data_o      = data_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule

// File: doc/md5_feeder.md
# md5_feeder

Front-end initiator for the `md5` hashing core. It accepts an arbitrary-length message as a byte stream and packs it into little-endian 32-bit MD5 words. It applies standard MD5 padding: 0x80, zeros, then the 64-bit little-endian bit length. Each 512-bit block is delivered to the core as four 128-bit `load` beats, pacing blocks on the core's `ready` pulse and signalling end-of-message digest completion.

## Interface
- `LEN_W`, default 32: byte-counter width, legal range 8..61. Bit length is `{byte_cnt, 3'b000}`, zero-extended to 64 bits.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `din_valid_i`  in  1  input byte valid.
- `din_i`  in  8  message byte.
- `din_last_i`  in  1  marks the final byte of a message; qualified by `din_valid_i`.
- `din_ready_o`  out  1  byte accepted when `din_valid_i & din_ready_o`.
- `newtext_o`  out  1  one-cycle pulse to core `newtext_i` at message start.
- `load_o`  out  1  one-cycle beat strobe to core `load_i`.
- `data_o`  out  128  beat to core `data_i`.
- `core_ready_i`  in  1  core `ready_o`, a one-cycle pulse when the block hash completes.
- `busy_o`  out  1  high from leaving IDLE until `done_o`.
- `done_o`  out  1  one-cycle pulse when the final block's hash completes.

## Operation
- **Packing:**
  - Block position `pos = beat_idx*16 + byte_idx`, range 0..63.
  - Byte `k` of 32-bit word `w` lands in bits `[8k+7:8k]` of that word.
  - Word 0 of a beat occupies `data_o[127:96]`; word 3 occupies `[31:0]`.
- **States and transitions:**
  - IDLE: on `din_valid_i` go to NEWTEXT. No byte is consumed.
  - NEWTEXT: `newtext_o=1` for one cycle; clear `byte_cnt`, `pos`, and pad flags; go to FILL.
  - FILL: `din_ready_o=1`. Accept one byte per cycle and increment `byte_cnt`. Byte 15 of a beat goes to LOAD. An accepted `din_last_i` sets `pad_mode`; that byte is still stored.
  - PAD: `din_ready_o=0`. Generate one pad byte per cycle:
    - At the first pad position, emit 0x80 and set `sent80`.
    - Otherwise emit 0x00.
    - On reaching `pos==56` with `sent80` set, set `len_ok`.
    - While `len_ok` is set, positions 56..63 emit bit-length byte `pos-56`.
    - Byte 15 of a beat goes to LOAD.
  - LOAD: `load_o=1` and `data_o=beat` for one cycle, then increment `beat_idx`.
    - If `beat_idx` was 3, go to WAIT.
    - Otherwise return to FILL, or to PAD if `pad_mode` is set.
  - WAIT: hold until `core_ready_i`. Then:
    - If `len_ok` is set, pulse `done_o` and go to IDLE.
    - Else if `pad_mode` is set, go to PAD.
    - Else go to FILL.
- **Boundaries:**
  - Last byte at `pos` 54 (55 bytes used in the block): single block.
  - Last byte at `pos` 55 (56 bytes used): 0x80 lands at position 56, `len_ok` stays clear, and an extra all-pad block follows.
  - Last byte completes a block: 0x80 is at position 0 of the next block.
  - `byte_cnt` wraps modulo 2^LEN_W. Longer messages are unsupported.
- **Ignored inputs:** `core_ready_i` outside WAIT is ignored. `din_valid_i` during PAD, LOAD, or WAIT is held off and never lost.
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - A reset mid-message discards everything.
  - The core must be reset simultaneously (top-level inversion to its active-low `reset`).

## Timing
- All outputs are registered.
- Per block: 64 byte/pad cycles, plus 4 LOAD cycles, plus the core hash time.
- `newtext_o` precedes the first `load_o` by at least 16 cycles.
- `load_o` never coincides with `newtext_o`.
- `done_o` is asserted the cycle after the final `core_ready_i`.
- First byte accept latency from IDLE is 2 cycles.

## Configuration
- `MD5_FEEDER_EMPTY_EN`: adds input `msg_empty_i`, width 1.
  - A pulse in IDLE performs NEWTEXT and then enters PAD directly with `byte_cnt=0`.
  - Result: one block containing only 0x80 at position 0 and length 0.
- Without the macro, the port is absent and empty messages cannot be hashed.

## Structure
- Shared package `md5_pkg`, which holds:
  - the state enum;
  - `MD5_PAD_BYTE = 8'h80`;
  - `MD5_LEN_POS = 56`;
  - `MD5_BEATS = 4`.
- Sub-module `md5_pad_byte_gen`: combinational selection of the pad byte from `pos`, `sent80`, `len_ok`, and the bit length.

## Test plan
- Message "abc" (0x61,0x62,0x63, last) produces:
  - `newtext_o`, then beat0 = `{32'h80636261, 96'h0}`;
  - beats 1–2 all zeros;
  - beat3 = `{64'h0, 32'h00000018, 32'h0}`;
  - `done_o` after one `core_ready_i`.
- 55-byte message produces one block whose beat3 word2 is `32'h000001B8`.
- 56-byte message produces two blocks:
  - block 1 word14 is `32'h00000080`;
  - block 2 is all zeros except word14 = `32'h000001C0`.
- 64-byte message produces block 2 with word0 = `32'h00000080` and word14 = `32'h00000200`.
- With `core_ready_i` delayed 100 cycles after block 1:
  - no `load_o` is issued;
  - `din_ready_o` stays 0 until the pulse;
  - a stray `core_ready_i` in FILL is ignored.
- Reset asserted mid-FILL: all outputs drop to 0 immediately. A subsequent "abc" reproduces the first scenario exactly.
- With `MD5_FEEDER_EMPTY_EN` defined, a `msg_empty_i` pulse produces beat0 = `{32'h00000080, 96'h0}` and beats 1–3 all zeros.
